cache_line_ram: RTL and testbench

Parametrised cache data store holding DEPTH lines of LINE_WORDS words each, with a clocked line read port, a full-line write port and a word-serial line-fill engine. It sits between the core's cache controller and the memory interface: the controller reads whole lines, and the bus interface streams refill words into a selected line. Per-line valid bits distinguish filled lines from empty ones; an empty line reads as zero.

---
 rtl/cache_line_ram_pkg.sv | 13 +
 rtl/cache_line_fill_ctrl.sv | 99 +++++++++
 rtl/cache_line_ram.sv | 125 ++++++++++++
 tb/tb_cache_line_ram.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_line_ram_pkg.sv
// Shared constants and fill FSM state type for the cache line store.
package cache_line_ram_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/cache_line_fill_ctrl.sv
// Word-serial refill sequencer: tracks the line being filled, counts beats,
// resolves aborts from inv_all / same-line full writes, and emits the
// per-beat word-write strobe plus valid-bit clear/set requests.
//
// state | meaning
// IDLE  | no refill in progress; fill_start latches a line and clears its valid
// FILL  | accepting fill_valid beats into word[cnt] of the latched line
module cache_line_fill_ctrl
  import cache_line_ram_pkg::*;
#(
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int SEL_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic             nGCLK,
  input  logic             nRESET,
  input  logic             fill_start,
  input  logic [SEL_W-1:0] fill_sel,
  input  logic             fill_valid,
  input  logic             wr_ena,
  input  logic [SEL_W-1:0] write_sel,
  input  logic             inv_all,
  output logic             fill_busy,
  output logic             fill_done,
  output logic [SEL_W-1:0] fill_line,
  output logic             clr_valid,
  output logic             set_valid,
  output logic             beat_we,
  output logic [CNT_W-1:0] beat_idx
);

  fill_state_t      state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [SEL_W-1:0] line_q, line_nxt;
  logic             done_q, done_nxt;
  logic             abort;

  // A same-line full write or a global invalidate ends the refill early.
  assign abort = inv_all | (wr_ena & (write_sel == line_q));

  // Next-state, beat strobe and valid-bit requests.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    line_nxt  = line_q;
    done_nxt  = 1'b0;
    beat_we   = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with inv_all is dropped: invalidate wins.
        if (fill_start && !inv_all) begin
          state_nxt = FILL;
          line_nxt  = fill_sel;
          cnt_nxt   = '0;
          clr_valid = 1'b1;
        end
      end
      FILL: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (fill_valid) begin
          beat_we = 1'b1;
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            set_valid = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, latched line and done pulse registers.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      line_q  <= line_nxt;
      done_q  <= done_nxt;
    end
  end

  assign fill_busy = (state_q == FILL);
  assign fill_done = done_q;
  assign fill_line = line_q;
  assign beat_idx  = cnt_q;

endmodule

// File: rtl/cache_line_ram.sv
// Cache data store: DEPTH lines of LINE_WORDS words, per-line valid bits,
// registered line read with write-first bypass, full-line write port and a
// word-serial refill engine.
module cache_line_ram
  import cache_line_ram_pkg::*;
#(
  parameter  int WORD_W     = WORD_W_DEF,
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int SEL_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(LINE_WORDS),
  localparam int LINE_W     = WORD_W * LINE_WORDS
) (
  input  logic              nGCLK,
  input  logic              nRESET,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_ack,
  output logic              rd_hit,
  output logic [LINE_W-1:0] read_port,
  input  logic              wr_ena,
  input  logic [SEL_W-1:0]  write_sel,
  input  logic [LINE_W-1:0] write_port,
  input  logic              fill_start,
  input  logic [SEL_W-1:0]  fill_sel,
  input  logic              fill_valid,
  input  logic [WORD_W-1:0] fill_word,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              inv_all
);

  logic [WORD_W-1:0] mem [DEPTH][LINE_WORDS];
  logic [DEPTH-1:0]  valid_q, valid_nxt;
  logic [SEL_W-1:0]  fill_line;
  logic              clr_valid, set_valid, beat_we;
  logic [CNT_W-1:0]  beat_idx;
  logic              rd_accept;
  logic [LINE_W-1:0] rd_line;

  cache_line_fill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .DEPTH      (DEPTH)
  ) u_fill_ctrl (
    .nGCLK      (nGCLK),
    .nRESET     (nRESET),
    .fill_start (fill_start),
    .fill_sel   (fill_sel),
    .fill_valid (fill_valid),
    .wr_ena     (wr_ena),
    .write_sel  (write_sel),
    .inv_all    (inv_all),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_line  (fill_line),
    .clr_valid  (clr_valid),
    .set_valid  (set_valid),
    .beat_we    (beat_we),
    .beat_idx   (beat_idx)
  );

  // Valid-bit update; a refill start clears its line after any same-cycle write
  // sets it, since the line is about to be overwritten word by word.
  always_comb begin
    valid_nxt = valid_q;
    if (inv_all) begin
      valid_nxt = '0;
    end else begin
      if (wr_ena)    valid_nxt[write_sel] = 1'b1;
      if (clr_valid) valid_nxt[fill_sel]  = 1'b0;
      if (set_valid) valid_nxt[fill_line] = 1'b1;
    end
  end

  // Valid vector register.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) valid_q <= '0;
    else         valid_q <= valid_nxt;
  end

  // Data array writes; contents are deliberately left unreset.
  always_ff @(posedge nGCLK) begin
    if (wr_ena) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        mem[write_sel][w] <= write_port[w*WORD_W +: WORD_W];
      end
    end
    if (beat_we) begin
      mem[fill_line][beat_idx] <= fill_word;
    end
  end

  // Reads of the line currently being refilled wait until the fill ends.
  assign rd_accept = rd_req & ~(fill_busy & (rd_sel == fill_line));

  // Write-first view of the selected line: same-cycle writes and beats win.
  always_comb begin
    rd_line = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line[w*WORD_W +: WORD_W] = mem[rd_sel][w];
      if (wr_ena && (write_sel == rd_sel)) begin
        rd_line[w*WORD_W +: WORD_W] = write_port[w*WORD_W +: WORD_W];
      end
      if (beat_we && (fill_line == rd_sel) && (beat_idx == CNT_W'(w))) begin
        rd_line[w*WORD_W +: WORD_W] = fill_word;
      end
    end
  end

  // Read result register; holds its last value when no request is accepted.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_ack    <= 1'b0;
      rd_hit    <= 1'b0;
      read_port <= '0;
    end else begin
      rd_ack <= rd_accept;
      if (rd_accept) begin
        rd_hit    <= valid_nxt[rd_sel];
        read_port <= valid_nxt[rd_sel] ? rd_line : '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_line_ram.sv
// Directed bench for cache_line_ram: reset, write-first reads, refills with
// blocked/unblocked reads, stalls, same-line write abort, invalidate and reset.
module tb_cache_line_ram;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int DEPTH      = 16;
  localparam int SEL_W      = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  logic              nGCLK = 1'b0;
  logic              nRESET;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_ack;
  logic              rd_hit;
  logic [LINE_W-1:0] read_port;
  logic              wr_ena;
  logic [SEL_W-1:0]  write_sel;
  logic [LINE_W-1:0] write_port;
  logic              fill_start;
  logic [SEL_W-1:0]  fill_sel;
  logic              fill_valid;
  logic [WORD_W-1:0] fill_word;
  logic              fill_busy;
  logic              fill_done;
  logic              inv_all;

  int total  = 0;
  int passed = 0;

  logic [LINE_W-1:0] exp_line2, exp_line4, pat5, pat9, pat6;

  cache_line_ram dut (
    .nGCLK      (nGCLK),
    .nRESET     (nRESET),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_ack     (rd_ack),
    .rd_hit     (rd_hit),
    .read_port  (read_port),
    .wr_ena     (wr_ena),
    .write_sel  (write_sel),
    .write_port (write_port),
    .fill_start (fill_start),
    .fill_sel   (fill_sel),
    .fill_valid (fill_valid),
    .fill_word  (fill_word),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .inv_all    (inv_all)
  );

  always #5 nGCLK = ~nGCLK;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge nGCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRESET = 1'b0; rd_req = 0; rd_sel = 0; wr_ena = 0; write_sel = 0; write_port = '0;
    fill_start = 0; fill_sel = 0; fill_valid = 0; fill_word = '0; inv_all = 0;
    pat5 = {LINE_WORDS{32'he1a00000}};
    pat9 = {LINE_WORDS{32'h00000909}};
    pat6 = {LINE_WORDS{32'hc0de0006}};
    for (int k = 0; k < LINE_WORDS; k++) begin
      exp_line2[k*WORD_W +: WORD_W] = WORD_W'(k);
      exp_line4[k*WORD_W +: WORD_W] = 32'h40 + WORD_W'(k);
    end

    // Reset state
    #22;
    chk("rst_rd_ack", LINE_W'(rd_ack), LINE_W'(0));
    chk("rst_rd_hit", LINE_W'(rd_hit), LINE_W'(0));
    chk("rst_read_port", read_port, '0);
    chk("rst_fill_busy", LINE_W'(fill_busy), LINE_W'(0));
    chk("rst_fill_done", LINE_W'(fill_done), LINE_W'(0));
    nRESET = 1'b1;
    cyc();

    // Read of an empty line
    rd_req = 1; rd_sel = 3;
    cyc();
    rd_req = 0;
    chk("empty_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("empty_hit", LINE_W'(rd_hit), LINE_W'(0));
    chk("empty_port", read_port, '0);

    // Full-line write with same-cycle read (write-first)
    wr_ena = 1; write_sel = 5; write_port = pat5; rd_req = 1; rd_sel = 5;
    cyc();
    wr_ena = 0; rd_req = 0;
    chk("wf_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("wf_hit", LINE_W'(rd_hit), LINE_W'(1));
    chk("wf_port", read_port, pat5);
    cyc();
    chk("hold_ack", LINE_W'(rd_ack), LINE_W'(0));
    chk("hold_port", read_port, pat5);

    // Refill line 2 with a blocked read held throughout
    fill_start = 1; fill_sel = 2;
    cyc();
    fill_start = 0;
    chk("f2_busy_rise", LINE_W'(fill_busy), LINE_W'(1));
    rd_req = 1; rd_sel = 2;
    for (int k = 0; k < LINE_WORDS; k++) begin
      fill_valid = 1; fill_word = WORD_W'(k);
      cyc();
      chk($sformatf("f2_blocked_ack_%0d", k), LINE_W'(rd_ack), LINE_W'(0));
      chk($sformatf("f2_done_%0d", k), LINE_W'(fill_done), LINE_W'(k == LINE_WORDS-1));
    end
    fill_valid = 0;
    chk("f2_busy_fall", LINE_W'(fill_busy), LINE_W'(0));
    cyc();
    rd_req = 0;
    chk("f2_rd_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("f2_rd_hit", LINE_W'(rd_hit), LINE_W'(1));
    chk("f2_rd_port", read_port, exp_line2);
    chk("f2_done_low", LINE_W'(fill_done), LINE_W'(0));

    // Stalled refill of line 4 with an unrelated read of line 9
    wr_ena = 1; write_sel = 9; write_port = pat9;
    cyc();
    wr_ena = 0;
    fill_start = 1; fill_sel = 4;
    cyc();
    fill_start = 0;
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1; fill_word = 32'h40 + WORD_W'(k);
      cyc();
    end
    fill_valid = 0; rd_req = 1; rd_sel = 9;
    cyc();
    rd_req = 0;
    chk("f4_rd9_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("f4_rd9_hit", LINE_W'(rd_hit), LINE_W'(1));
    chk("f4_rd9_port", read_port, pat9);
    cyc();
    cyc();
    chk("f4_stall_busy", LINE_W'(fill_busy), LINE_W'(1));
    chk("f4_stall_done", LINE_W'(fill_done), LINE_W'(0));
    for (int k = 4; k < LINE_WORDS; k++) begin
      fill_valid = 1; fill_word = 32'h40 + WORD_W'(k);
      cyc();
    end
    fill_valid = 0;
    chk("f4_done", LINE_W'(fill_done), LINE_W'(1));
    rd_req = 1; rd_sel = 4;
    cyc();
    rd_req = 0;
    chk("f4_rd_hit", LINE_W'(rd_hit), LINE_W'(1));
    chk("f4_rd_port", read_port, exp_line4);

    // Refill line 6 aborted by a same-line write (beat in same cycle loses)
    fill_start = 1; fill_sel = 6;
    cyc();
    fill_start = 0;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1; fill_word = 32'h60 + WORD_W'(k);
      cyc();
    end
    fill_word = 32'hdeadbeef; wr_ena = 1; write_sel = 6; write_port = pat6;
    cyc();
    wr_ena = 0; fill_valid = 0;
    chk("f6_abort_busy", LINE_W'(fill_busy), LINE_W'(0));
    chk("f6_abort_done", LINE_W'(fill_done), LINE_W'(0));
    rd_req = 1; rd_sel = 6;
    cyc();
    rd_req = 0;
    chk("f6_no_done", LINE_W'(fill_done), LINE_W'(0));
    chk("f6_rd_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("f6_rd_hit", LINE_W'(rd_hit), LINE_W'(1));
    chk("f6_rd_port", read_port, pat6);

    // Lines 0-7 valid, then inv_all during a refill of line 8
    for (int l = 0; l < 8; l++) begin
      wr_ena = 1; write_sel = SEL_W'(l); write_port = {LINE_WORDS{32'h11110000 + WORD_W'(l)}};
      cyc();
    end
    wr_ena = 0;
    rd_req = 1; rd_sel = 7;
    cyc();
    rd_req = 0;
    chk("pre_inv_hit7", LINE_W'(rd_hit), LINE_W'(1));
    fill_start = 1; fill_sel = 8;
    cyc();
    fill_start = 0;
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1; fill_word = WORD_W'(k);
      cyc();
    end
    fill_valid = 0; inv_all = 1;
    cyc();
    inv_all = 0;
    chk("inv_busy", LINE_W'(fill_busy), LINE_W'(0));
    chk("inv_done", LINE_W'(fill_done), LINE_W'(0));
    rd_req = 1; rd_sel = 0;
    cyc();
    chk("inv_rd0_hit", LINE_W'(rd_hit), LINE_W'(0));
    chk("inv_rd0_port", read_port, '0);
    rd_sel = 5;
    cyc();
    rd_req = 0;
    chk("inv_rd5_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("inv_rd5_hit", LINE_W'(rd_hit), LINE_W'(0));
    chk("inv_rd5_port", read_port, '0);

    // Asynchronous reset in the middle of a refill of line 3
    wr_ena = 1; write_sel = 3; write_port = pat5;
    cyc();
    wr_ena = 0;
    fill_start = 1; fill_sel = 3;
    cyc();
    fill_start = 0;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1; fill_word = WORD_W'(k);
      cyc();
    end
    fill_valid = 0;
    chk("pre_rst_busy", LINE_W'(fill_busy), LINE_W'(1));
    #2 nRESET = 1'b0;
    #1;
    chk("rst_mid_busy", LINE_W'(fill_busy), LINE_W'(0));
    chk("rst_mid_done", LINE_W'(fill_done), LINE_W'(0));
    #3 nRESET = 1'b1;
    rd_req = 1; rd_sel = 3;
    cyc();
    chk("post_rst_ack", LINE_W'(rd_ack), LINE_W'(1));
    chk("post_rst_hit3", LINE_W'(rd_hit), LINE_W'(0));
    chk("post_rst_port3", read_port, '0);
    rd_sel = 2;
    cyc();
    rd_req = 0;
    chk("post_rst_hit2", LINE_W'(rd_hit), LINE_W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
